ps2_key_ctrl: RTL and testbench
===============================

Name: ps2_key_ctrl

Overview:
- Sequencer between the ps2_key receiver FIFO and keyboard consumers (segment display, event logic).
- Pops bytes from the receiver with the active-low nextdata_n handshake.
- Assembles multi-byte scancode sequences (E0 prefix, F0 break prefix) into single key events, delivered over a valid/ready interface.
- Suppresses typematic repeats, tracks the held key, keeps a saturating BCD press count and a sticky overflow flag.

Parameters:
- FILTER_REPEAT, 1, 1 = drop repeated make codes of the currently held key; 0 = emit every make.
- CNT_MAX, 99, press-count saturation value (decimal, ≤99).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous, active-low reset
- rx_data  in  8  receiver FIFO head byte
- rx_ready  in  1  receiver FIFO non-empty
- rx_overflow  in  1  receiver FIFO overflow (level)
- rx_next_n  out  1  active-low pop strobe to receiver
- evt_valid  out  1  key event available
- evt_ready  in  1  consumer accepts event
- evt_code  out  8  scancode, prefixes stripped
- evt_ext  out  1  event was E0-prefixed
- evt_break  out  1  1 = release, 0 = press
- held  out  1  a key is currently held
- held_code  out  8  code of the held key (0x00 when none)
- press_bcd  out  8  press count, two BCD digits {tens, ones}
- ovf_flag  out  1  sticky overflow seen
- ovf_clr  in  1  clears ovf_flag

Behaviour:
- Reset values: rx_next_n=1, evt_valid=0, evt_code=0, evt_ext=0, evt_break=0, held=0, held_code=0, press_bcd=0x00, ovf_flag=0. FSM enters S_IDLE and prefix flags ext_f and brk_f are cleared.
- S_IDLE: if rx_ready, latch rx_data into byte_q; next state S_POP.
- S_POP: rx_next_n=0 for exactly this one cycle; next state S_GAP.
- S_GAP: rx_next_n=1; decode byte_q.
  - 0xE0: set ext_f; go to S_IDLE.
  - 0xF0: set brk_f; go to S_IDLE.
  - Any other byte: build the event {byte_q, ext_f, brk_f}.
- Repeat filter: a make event whose code and ext equal the held key while held=1 is a repeat. With FILTER_REPEAT=1 it is dropped: clear flags, go to S_IDLE, no counter change.
- Accepted make: held=1, held_code=code; press_bcd increments with BCD carry (0x09 to 0x10); saturates at CNT_MAX.
- Break matching the held key (code and ext): held=0, held_code=0. A break of any other key only emits the event.
- After state updates: evt_* registered, evt_valid=1; next state S_EMIT.
- S_EMIT: hold all evt_* stable while evt_valid and !evt_ready. On evt_valid&&evt_ready: evt_valid=0 next cycle, clear ext_f/brk_f, go to S_IDLE.
- No FIFO pops occur while in S_EMIT (backpressure).
- Latency: rx_ready high to evt_valid high is 3 cycles for a single-byte code. E0 F0 xx takes three pop sequences.
- Minimum byte spacing is 3 cycles. rx_ready is never sampled in S_GAP, so the FIFO pointer update is always observed before the next pop.
- Overflow:
  - rx_overflow=1 in any state sets ovf_flag and clears ext_f, brk_f and held.
  - A pending S_EMIT event still completes.
  - In S_IDLE/S_POP/S_GAP the partially assembled sequence is discarded and the FSM returns to S_IDLE after the current pop completes.
- Flag clear: ovf_clr clears ovf_flag. Simultaneous set and clear: set wins.
- Reset mid-sequence: all state returns to reset values. rx_next_n returns high the next cycle, so no partial pop remains.

Decomposition:
- Shared package ps2_pkg holds:
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0;
  - FSM state enum {S_IDLE, S_POP, S_GAP, S_EMIT};
  - key event struct {code, ext, brk}.
- One sub-module: bcd_sat_cnt (2-digit BCD incrementer with saturation, inputs inc/clr, param MAX).

Test Plan:
- Feed 0x1C alone with evt_ready=1: exactly one rx_next_n low pulse; evt_valid 3 cycles later with code=0x1C, ext=0, break=0; held=1, held_code=0x1C, press_bcd=0x01.
- Feed 1C,1C,1C,F0,1C with FILTER_REPEAT=1: exactly two events (make 0x1C, break 0x1C); press_bcd=0x01; held=0 at end. With FILTER_REPEAT=0: four events, press_bcd=0x03.
- Feed E0,F0,75 (break of arrow up): a single event with code=0x75, ext=1, break=1; three rx_next_n pulses.
- Hold evt_ready=0 for 20 cycles with 0x16 pending and more bytes queued: evt_* stay stable, no rx_next_n pulses; pops resume after the handshake.
- Apply 105 distinct make/break pairs: press_bcd passes 0x09 to 0x10 and saturates at 0x99.
- Assert rx_overflow after an E0 byte, then feed 0x1C: ovf_flag=1; the event arrives with ext=0; ovf_clr returns ovf_flag to 0; asserting rstn=0 mid-sequence gives rx_next_n=1 and all outputs at reset values.

Source files
------------

// File: rtl/ps2_key_ctrl_pkg.sv
// Shared definitions for the PS/2 key sequencer: prefix bytes, FSM states,
// the assembled key event and a BCD conversion helper.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_POP  = 2'd1,
      S_GAP  = 2'd2,
      S_EMIT = 2'd3
   } state_e;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
   } key_evt_t;

   function automatic logic [7:0] to_bcd(input int unsigned val);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'(val / 32'd10);
      ones = 4'(val % 32'd10);
      return {tens, ones};
   endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Receiver-FIFO pop handshake and key-event valid/ready channel.
interface ps2_key_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       rx_overflow;
   logic       rx_next_n;
   logic       evt_valid;
   logic       evt_ready;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_break;

   modport master (
      input  rx_data, rx_ready, rx_overflow, evt_ready,
      output rx_next_n, evt_valid, evt_code, evt_ext, evt_break
   );

   modport slave (
      output rx_data, rx_ready, rx_overflow, evt_ready,
      input  rx_next_n, evt_valid, evt_code, evt_ext, evt_break
   );
endinterface

// File: rtl/ps2_key_ctrl_bcd_sat_cnt.sv
// Two-digit BCD up-counter that stops at MAX (given in decimal, at most 99).
module bcd_sat_cnt
   import ps2_pkg::*;
#(
   parameter int unsigned MAX = 32'd99
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       inc,
   input  logic       clr,
   output logic [7:0] cnt
);

   localparam logic [7:0] MAX_BCD = to_bcd(MAX);

   logic [7:0] cnt_r;

   // BCD increment with ones-to-tens carry, holding at the saturation value
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_r <= 8'h00;
      end else if (clr) begin
         cnt_r <= 8'h00;
      end else if (inc && (cnt_r != MAX_BCD)) begin
         if (cnt_r[3:0] == 4'd9) begin
            cnt_r <= {cnt_r[7:4] + 4'd1, 4'd0};
         end else begin
            cnt_r <= {cnt_r[7:4], cnt_r[3:0] + 4'd1};
         end
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/ps2_key_ctrl.sv
// Pops scancode bytes from the PS/2 receiver FIFO, folds E0/F0 prefixes into
// single key events, filters typematic repeats and tracks held key and press count.
module ps2_key_ctrl
   import ps2_pkg::*;
#(
   parameter bit          FILTER_REPEAT = 1'b1,
   parameter int unsigned CNT_MAX       = 32'd99
) (
   input  logic                  clk,
   input  logic                  rstn,
   ps2_key_ctrl_if.master        bus,
   output logic                  held,
   output logic [7:0]            held_code,
   output logic [7:0]            press_bcd,
   output logic                  ovf_flag,
   input  logic                  ovf_clr
);

   state_e     state_r;
   logic [7:0] byte_r;
   logic       ext_r;
   logic       brk_r;
   logic       drop_r;
   logic       rx_next_n_r;
   logic       evt_valid_r;
   key_evt_t   evt_r;
   logic       held_r;
   logic [7:0] held_code_r;
   logic       held_ext_r;
   logic       ovf_r;

   key_evt_t   cand_s;
   logic       is_prefix_s;
   logic       same_key_s;
   logic       repeat_s;
   logic       release_s;
   logic       inc_s;

   // Decode of the byte sitting in byte_r against prefix flags and the held key
   always_comb begin
      cand_s.code = byte_r;
      cand_s.ext  = ext_r;
      cand_s.brk  = brk_r;
      is_prefix_s = (byte_r == PS2_EXT) || (byte_r == PS2_BRK);
      same_key_s  = held_r && (byte_r == held_code_r) && (ext_r == held_ext_r);
      repeat_s    = same_key_s && !brk_r;
      release_s   = same_key_s && brk_r;
      if ((state_r == S_GAP) && !bus.rx_overflow && !drop_r && !is_prefix_s &&
          !brk_r && !(FILTER_REPEAT && repeat_s)) begin
         inc_s = 1'b1;
      end else begin
         inc_s = 1'b0;
      end
   end

   // Sequencer FSM with registered pop strobe, event and held-key outputs
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r     <= S_IDLE;
         byte_r      <= 8'h00;
         ext_r       <= 1'b0;
         brk_r       <= 1'b0;
         drop_r      <= 1'b0;
         rx_next_n_r <= 1'b1;
         evt_valid_r <= 1'b0;
         evt_r       <= '0;
         held_r      <= 1'b0;
         held_code_r <= 8'h00;
         held_ext_r  <= 1'b0;
         ovf_r       <= 1'b0;
      end else begin
         if (bus.rx_overflow) begin
            ovf_r <= 1'b1;
         end else if (ovf_clr) begin
            ovf_r <= 1'b0;
         end

         case (state_r)
            S_IDLE: begin
               rx_next_n_r <= 1'b1;
               if (!bus.rx_overflow && bus.rx_ready) begin
                  byte_r      <= bus.rx_data;
                  drop_r      <= 1'b0;
                  rx_next_n_r <= 1'b0;
                  state_r     <= S_POP;
               end
            end
            S_POP: begin
               rx_next_n_r <= 1'b1;
               state_r     <= S_GAP;
               // the pop must still finish; the byte is discarded in S_GAP
               if (bus.rx_overflow) begin
                  drop_r <= 1'b1;
               end
            end
            S_GAP: begin
               rx_next_n_r <= 1'b1;
               if (bus.rx_overflow || drop_r) begin
                  ext_r   <= 1'b0;
                  brk_r   <= 1'b0;
                  drop_r  <= 1'b0;
                  state_r <= S_IDLE;
               end else if (byte_r == PS2_EXT) begin
                  ext_r   <= 1'b1;
                  state_r <= S_IDLE;
               end else if (byte_r == PS2_BRK) begin
                  brk_r   <= 1'b1;
                  state_r <= S_IDLE;
               end else if (FILTER_REPEAT && repeat_s) begin
                  ext_r   <= 1'b0;
                  brk_r   <= 1'b0;
                  state_r <= S_IDLE;
               end else begin
                  if (!brk_r) begin
                     held_r      <= 1'b1;
                     held_code_r <= byte_r;
                     held_ext_r  <= ext_r;
                  end else if (release_s) begin
                     held_r      <= 1'b0;
                     held_code_r <= 8'h00;
                     held_ext_r  <= 1'b0;
                  end
                  evt_r       <= cand_s;
                  evt_valid_r <= 1'b1;
                  state_r     <= S_EMIT;
               end
            end
            S_EMIT: begin
               rx_next_n_r <= 1'b1;
               if (evt_valid_r && bus.evt_ready) begin
                  evt_valid_r <= 1'b0;
                  ext_r       <= 1'b0;
                  brk_r       <= 1'b0;
                  state_r     <= S_IDLE;
               end
            end
            default: begin
               rx_next_n_r <= 1'b1;
               evt_valid_r <= 1'b0;
               state_r     <= S_IDLE;
            end
         endcase

         // overflow invalidates any partial prefix and the held-key tracking
         if (bus.rx_overflow) begin
            ext_r       <= 1'b0;
            brk_r       <= 1'b0;
            held_r      <= 1'b0;
            held_code_r <= 8'h00;
            held_ext_r  <= 1'b0;
         end
      end
   end

   bcd_sat_cnt #(
      .MAX (CNT_MAX)
   ) u_press_cnt (
      .clk  (clk),
      .rstn (rstn),
      .inc  (inc_s),
      .clr  (1'b0),
      .cnt  (press_bcd)
   );

   assign bus.rx_next_n = rx_next_n_r;
   assign bus.evt_valid = evt_valid_r;
   assign bus.evt_code  = evt_r.code;
   assign bus.evt_ext   = evt_r.ext;
   assign bus.evt_break = evt_r.brk;
   assign held          = held_r;
   assign held_code     = held_code_r;
   assign ovf_flag      = ovf_r;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: a FIFO model feeds bytes, expected events
// are queued by the stimulus and matched by a monitor on each handshake.
module tb_ps2_key_ctrl;
   import ps2_pkg::*;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       held, held0;
   logic [7:0] held_code, held_code0;
   logic [7:0] press_bcd, press_bcd0;
   logic       ovf_flag, ovf_flag0;
   logic       ovf_clr;

   ps2_key_ctrl_if bus ();
   ps2_key_ctrl_if bus0 ();

   ps2_key_ctrl #(.FILTER_REPEAT(1'b1), .CNT_MAX(32'd99)) dut (
      .clk(clk), .rstn(rstn), .bus(bus), .held(held), .held_code(held_code),
      .press_bcd(press_bcd), .ovf_flag(ovf_flag), .ovf_clr(ovf_clr)
   );

   ps2_key_ctrl #(.FILTER_REPEAT(1'b0), .CNT_MAX(32'd99)) dut0 (
      .clk(clk), .rstn(rstn), .bus(bus0), .held(held0), .held_code(held_code0),
      .press_bcd(press_bcd0), .ovf_flag(ovf_flag0), .ovf_clr(1'b0)
   );

   always #5 clk = ~clk;

   logic [7:0] fifo[$];
   logic [7:0] fifo0[$];
   key_evt_t   exp_q[$];
   key_evt_t   exp0_q[$];
   int         nchk = 0;
   int         nerr = 0;
   int         cyc = 0;
   int         pops = 0;
   int         ev0 = 0;
   bit         pop_s, pop0_s;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      nchk++;
      nerr++;
      $display("FAIL %s: timed out waiting", nm);
   endtask

   task automatic ex(input logic [7:0] c, input logic e, input logic b);
      key_evt_t k;
      k.code = c; k.ext = e; k.brk = b;
      exp_q.push_back(k);
   endtask

   task automatic ex0(input logic [7:0] c, input logic e, input logic b);
      key_evt_t k;
      k.code = c; k.ext = e; k.brk = b;
      exp0_q.push_back(k);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((fifo.size() != 0 || fifo0.size() != 0 || exp_q.size() != 0 ||
              exp0_q.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) timeout("wait_idle");
      repeat (6) @(negedge clk);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   // Receiver FIFO model: pops on a low strobe seen at the edge, presents the head after it
   always @(posedge clk) begin
      pop_s  = !bus.rx_next_n;
      pop0_s = !bus0.rx_next_n;
      cyc    = cyc + 1;
      #1;
      if (pop_s) begin
         pops++;
         if (fifo.size() > 0) void'(fifo.pop_front());
      end
      if (pop0_s && fifo0.size() > 0) void'(fifo0.pop_front());
      bus.rx_ready  = (fifo.size() > 0);
      bus.rx_data   = (fifo.size() > 0) ? fifo[0] : 8'h00;
      bus0.rx_ready = (fifo0.size() > 0);
      bus0.rx_data  = (fifo0.size() > 0) ? fifo0[0] : 8'h00;
   end

   // Monitor: every accepted event is matched against the scoreboard head
   always @(negedge clk) begin
      key_evt_t a, e;
      if (bus.evt_valid && bus.evt_ready) begin
         a.code = bus.evt_code; a.ext = bus.evt_ext; a.brk = bus.evt_break;
         if (exp_q.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL evt_unexpected: got %h ext=%b brk=%b, none expected", a.code, a.ext, a.brk);
         end else begin
            e = exp_q.pop_front();
            chk("evt", 32'(a), 32'(e));
         end
      end
      if (bus0.evt_valid && bus0.evt_ready) begin
         ev0++;
         a.code = bus0.evt_code; a.ext = bus0.evt_ext; a.brk = bus0.evt_break;
         if (exp0_q.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL evt0_unexpected: got %h ext=%b brk=%b, none expected", a.code, a.ext, a.brk);
         end else begin
            e = exp0_q.pop_front();
            chk("evt0", 32'(a), 32'(e));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   logic [7:0] rep_seq [5] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};

   initial begin
      int p0, p1, rc, n, bad, e0, cnt;
      logic [7:0] code;
      bus.rx_overflow = 1'b0;  bus.evt_ready = 1'b1;
      bus.rx_ready = 1'b0;     bus.rx_data = 8'h00;
      bus0.rx_overflow = 1'b0; bus0.evt_ready = 1'b1;
      bus0.rx_ready = 1'b0;    bus0.rx_data = 8'h00;
      ovf_clr = 1'b0;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_next_n", 32'(bus.rx_next_n), 32'd1);
      chk("rst_valid", 32'(bus.evt_valid), 32'd0);
      chk("rst_code", 32'(bus.evt_code), 32'h00);
      chk("rst_held", 32'(held), 32'd0);
      chk("rst_held_code", 32'(held_code), 32'h00);
      chk("rst_press", 32'(press_bcd), 32'h00);
      chk("rst_ovf", 32'(ovf_flag), 32'd0);
      rstn = 1'b1;
      @(negedge clk);

      // single byte: latency and held tracking
      p0 = pops;
      fifo.push_back(8'h1C);
      ex(8'h1C, 1'b0, 1'b0);
      n = 0;
      while (!bus.rx_ready && n < 20) begin @(negedge clk); n++; end
      rc = cyc;
      n = 0;
      while (!bus.evt_valid && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) timeout("evt_valid");
      chk("latency", 32'(cyc - rc), 32'd3);
      wait_idle(200);
      chk("t1_pops", 32'(pops - p0), 32'd1);
      chk("t1_held", 32'(held), 32'd1);
      chk("t1_held_code", 32'(held_code), 32'h1C);
      chk("t1_press", 32'(press_bcd), 32'h01);

      // typematic repeats, filtered and unfiltered
      do_reset();
      p0 = pops;
      e0 = ev0;
      for (int i = 0; i < 5; i++) begin
         fifo.push_back(rep_seq[i]);
         fifo0.push_back(rep_seq[i]);
      end
      ex(8'h1C, 1'b0, 1'b0);  ex(8'h1C, 1'b0, 1'b1);
      ex0(8'h1C, 1'b0, 1'b0); ex0(8'h1C, 1'b0, 1'b0);
      ex0(8'h1C, 1'b0, 1'b0); ex0(8'h1C, 1'b0, 1'b1);
      wait_idle(400);
      chk("t2_pops", 32'(pops - p0), 32'd5);
      chk("t2_press", 32'(press_bcd), 32'h01);
      chk("t2_held", 32'(held), 32'd0);
      chk("t2_ev0", 32'(ev0 - e0), 32'd4);
      chk("t2_press0", 32'(press_bcd0), 32'h03);
      chk("t2_held0", 32'(held0), 32'd0);

      // extended break: E0 F0 75
      p0 = pops;
      fifo.push_back(8'hE0); fifo.push_back(8'hF0); fifo.push_back(8'h75);
      ex(8'h75, 1'b1, 1'b1);
      wait_idle(300);
      chk("t3_pops", 32'(pops - p0), 32'd3);
      chk("t3_press", 32'(press_bcd), 32'h01);

      // backpressure
      bus.evt_ready = 1'b0;
      p0 = pops;
      fifo.push_back(8'h16); fifo.push_back(8'h34);
      ex(8'h16, 1'b0, 1'b0); ex(8'h34, 1'b0, 1'b0);
      n = 0;
      while (!bus.evt_valid && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) timeout("bp_valid");
      p1 = pops;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!bus.evt_valid || bus.evt_code != 8'h16 || bus.evt_ext || bus.evt_break) bad++;
      end
      chk("bp_stable", 32'(bad), 32'd0);
      chk("bp_no_pop", 32'(pops - p1), 32'd0);
      chk("bp_first_pop", 32'(pops - p0), 32'd1);
      bus.evt_ready = 1'b1;
      wait_idle(200);
      chk("bp_pops", 32'(pops - p0), 32'd2);
      chk("bp_press", 32'(press_bcd), 32'h03);
      chk("bp_held_code", 32'(held_code), 32'h34);

      // press-count carry and saturation
      do_reset();
      cnt = 0;
      for (int i = 0; i < 105; i++) begin
         code = 8'(i + 1);
         fifo.push_back(code); fifo.push_back(8'hF0); fifo.push_back(code);
         ex(code, 1'b0, 1'b0); ex(code, 1'b0, 1'b1);
         wait_idle(200);
         cnt++;
         if (i == 8 || i == 9 || i == 98 || i == 104) begin
            n = (cnt > 99) ? 99 : cnt;
            chk("sat_press", 32'(press_bcd), {24'h0, 4'(n / 10), 4'(n % 10)});
         end
      end
      chk("sat_held", 32'(held), 32'd0);

      // overflow mid-sequence, sticky flag and clear priority
      do_reset();
      fifo.push_back(8'hE0);
      wait_idle(100);
      chk("ovf_pre", 32'(ovf_flag), 32'd0);
      bus.rx_overflow = 1'b1;
      @(negedge clk);
      bus.rx_overflow = 1'b0;
      chk("ovf_set", 32'(ovf_flag), 32'd1);
      fifo.push_back(8'h1C);
      ex(8'h1C, 1'b0, 1'b0);
      wait_idle(100);
      chk("ovf_sticky", 32'(ovf_flag), 32'd1);
      chk("ovf_held", 32'(held), 32'd1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("ovf_clr", 32'(ovf_flag), 32'd0);
      bus.rx_overflow = 1'b1;
      ovf_clr = 1'b1;
      @(negedge clk);
      bus.rx_overflow = 1'b0;
      ovf_clr = 1'b0;
      chk("ovf_set_wins", 32'(ovf_flag), 32'd1);
      chk("ovf_drops_held", 32'(held), 32'd0);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      fifo.push_back(8'h1C);
      ex(8'h1C, 1'b0, 1'b0);
      wait_idle(100);

      // reset in the middle of a pop
      fifo.push_back(8'h2A);
      n = 0;
      while (bus.rx_next_n && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) timeout("mid_pop");
      rstn = 1'b0;
      @(negedge clk);
      chk("mrst_next_n", 32'(bus.rx_next_n), 32'd1);
      chk("mrst_valid", 32'(bus.evt_valid), 32'd0);
      chk("mrst_code", 32'(bus.evt_code), 32'h00);
      chk("mrst_held", 32'(held), 32'd0);
      chk("mrst_held_code", 32'(held_code), 32'h00);
      chk("mrst_press", 32'(press_bcd), 32'h00);
      chk("mrst_ovf", 32'(ovf_flag), 32'd0);
      rstn = 1'b1;
      repeat (6) @(negedge clk);
      chk("mrst_quiet", 32'(bus.evt_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
